dmi_access_ctrl: RTL
====================

// Module: dmi_access_ctrl
// PURPOSE
//  DTM-side DMI access controller, upstream of the Debug Module.
//  - Turns a dmi scan-register UPDATE into one DMI request (valid/ready) to the DM.
//  - Waits for the DM response and holds the result for the next CAPTURE.
//  - Keeps the sticky dmistat (busy/failed) reported in dtmcs.
//  - Runs on sys_clk. TAP strobes arrive already synchronised as 1-cycle pulses.
// PARAMETERS
//  ABITS    7     DMI address width; request width = ABITS+34, response width = 34
//  TIMEOUT  1023  max cycles waiting for dm_resp_valid before failing (>=1)
// PORTS
//  sys_clk         in   1         system clock
//  sys_rstn        in   1         async active-low reset
//  dmi_update      in   1         pulse: UPDATE-DR on the dmi register
//  dmi_wr_bits     in   ABITS+34  {addr, data[31:0], op[1:0]} shifted in by the debugger
//  dmi_capture     in   1         pulse: CAPTURE-DR on the dmi register
//  dmi_rd_bits     out  ABITS+34  {addr, data, op} returned on capture
//  dmireset        in   1         pulse: clear sticky dmistat
//  dmihardreset    in   1         pulse: abandon the transaction and clear dmistat
//  dmistat         out  2         sticky status: 0 ok, 2 failed, 3 busy
//  dmi_busy        out  1         high while state != IDLE
//  dtm_req_valid   out  1         request to DM
//  dtm_req_ready   in   1         DM accepts the request
//  dtm_req_bits    out  ABITS+34  {addr, data, op}, op 1=read, 2=write
//  dm_resp_valid   in   1         DM response valid
//  dm_resp_ready   out  1         ready for the DM response
//  dm_resp_bits    in   34        {data[31:0], resp[1:0]}, resp 0 ok, 2 failed
// BEHAVIOUR
//  Reset values
//  - All outputs 0: state IDLE, dmistat 0, dmi_rd_bits 0, timeout counter 0.
//  States
//  - IDLE -> REQ: on dmi_update when dmistat==0 and op is 1 or 2.
//    The request is latched into dtm_req_bits the same edge; dtm_req_valid is high the next cycle.
//  - In IDLE, op 0 (nop) or op 3 (reserved) issues no request and leaves dmistat unchanged.
//    op 3 is treated as nop.
//  - REQ: dtm_req_valid=1 and dtm_req_bits are held stable until dtm_req_valid&dtm_req_ready.
//    On that handshake -> RESP and the counter is cleared.
//  - RESP: dm_resp_ready=1 and the counter increments each cycle.
//    On dm_resp_valid: latch data, latch the address of the request, latch op=resp, -> IDLE.
//    A resp of 2 also sets dmistat=2 when dmistat==0.
//    If the counter reaches TIMEOUT with no response: dmistat=2 (when 0), op=2, -> IDLE.
//  Update / capture rules
//  - dmi_update while dmi_busy: no new request; dmistat=3 (when dmistat==0).
//  - dmi_update while dmistat!=0: ignored, no request.
//  - dmi_capture in IDLE: dmi_rd_bits={last addr, last data, dmistat!=0 ? dmistat : last op}.
//  - dmi_capture while busy: op field=3; dmistat=3 (when dmistat==0).
//  Status clears
//  - dmireset: dmistat=0 next cycle. The state is not touched.
//  - dmihardreset: state->IDLE, dmistat=0, counter 0, dtm_req_valid/dm_resp_ready drop next cycle.
//    An in-flight DM response is discarded; the DM must tolerate the abandoned handshake.
//  Simultaneous events
//  - dmihardreset has priority over everything.
//  - dmi_capture is evaluated before dmi_update in the same cycle.
//  - A completion and a set-busy in the same cycle: the failed code (2) wins only when dmistat was 0 at cycle start.
//  - The sticky rule is first error wins; the code is never overwritten until cleared.
//  - dmireset together with a busy update: the clear wins.
// TESTING
//  1. Write addr 0x10, data 0x80000001, op 2; DM ready next cycle, resp 0 two cycles later
//     -> one valid/ready handshake, bits {0x10,0x80000001,2}; capture returns op 0, dmistat 0.
//  2. Read addr 0x04; DM returns {0xDEADBEEF,0}
//     -> capture gives {0x04,0xDEADBEEF,0}, dmi_busy low after the response cycle.
//  3. Second update while in RESP -> no second request; dmistat=3.
//     Later updates ignored; after dmireset a new read issues normally.
//  4. DM holds dm_resp_valid low, TIMEOUT=8 -> 8 cycles after acceptance: IDLE, dmistat=2, capture op=2.
//  5. dtm_req_ready held low 5 cycles -> dtm_req_bits stable throughout.
//     Hold dtm_req_ready low again and pulse dmihardreset mid-REQ -> valid drops, dmistat 0.
//  6. sys_rstn asserted in RESP -> all outputs 0 asynchronously; the first update after release is accepted.

Source files
------------

// File: rtl/dmi_access_ctrl.sv
// DTM-side DMI access controller: turns a dmi UPDATE into a single request
// to the Debug Module, waits for its response (with a timeout), holds the
// result for the next CAPTURE and keeps the sticky dmistat code.
module dmi_access_ctrl #(
    parameter int ABITS   = 7,
    parameter int TIMEOUT = 1023
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic             dmi_update,
    input  logic [ABITS+33:0] dmi_wr_bits,
    input  logic             dmi_capture,
    output logic [ABITS+33:0] dmi_rd_bits,
    input  logic             dmireset,
    input  logic             dmihardreset,
    output logic [1:0]       dmistat,
    output logic             dmi_busy,
    output logic             dtm_req_valid,
    input  logic             dtm_req_ready,
    output logic [ABITS+33:0] dtm_req_bits,
    input  logic             dm_resp_valid,
    output logic             dm_resp_ready,
    input  logic [33:0]      dm_resp_bits
);

    localparam int RW = ABITS + 34;
    // counter only has to hold 0..TIMEOUT-1
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [ABITS-1:0] last_addr;
    logic [31:0]     last_data;
    logic [1:0]      last_op;

    logic [1:0]      wr_op;
    logic            start, req_fire, resp_fire, tmo, set_fail, set_busy;

    assign wr_op         = dmi_wr_bits[1:0];
    assign dtm_req_valid = (state == REQ);
    assign dm_resp_ready = (state == RESP);
    assign dmi_busy      = (state != IDLE);

    // Next-state and per-cycle event strobes; hard reset overrides all transitions
    always_comb begin
        state_next = state;
        start      = 1'b0;
        req_fire   = 1'b0;
        resp_fire  = 1'b0;
        tmo        = 1'b0;
        set_fail   = 1'b0;
        if (dmihardreset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // nop (0) and reserved (3) never reach the DM
                    if (dmi_update && dmistat == 2'd0 && (wr_op == 2'd1 || wr_op == 2'd2)) begin
                        start      = 1'b1;
                        state_next = REQ;
                    end
                end
                REQ: begin
                    if (dtm_req_ready) begin
                        req_fire   = 1'b1;
                        state_next = RESP;
                    end
                end
                RESP: begin
                    if (dm_resp_valid) begin
                        resp_fire  = 1'b1;
                        set_fail   = (dm_resp_bits[1:0] == 2'd2);
                        state_next = IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        tmo        = 1'b1;
                        set_fail   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        // any scan access while a transaction is outstanding flags busy
        set_busy = (state != IDLE) && (dmi_update || dmi_capture);
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) state <= IDLE;
        else           state <= state_next;
    end

    // Request latch, timeout counter, result registers and sticky status
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            dtm_req_bits <= '0;
            dmi_rd_bits  <= '0;
            dmistat      <= 2'd0;
            cnt          <= '0;
            last_addr    <= '0;
            last_data    <= '0;
            last_op      <= 2'd0;
        end else if (dmihardreset) begin
            // the abandoned transaction leaves the last result untouched
            cnt     <= '0;
            dmistat <= 2'd0;
        end else begin
            if (start) dtm_req_bits <= dmi_wr_bits;

            if (req_fire || resp_fire || tmo) cnt <= '0;
            else if (state == RESP)           cnt <= cnt + 1'b1;

            if (resp_fire) begin
                last_addr <= dtm_req_bits[RW-1:34];
                last_data <= dm_resp_bits[33:2];
                last_op   <= dm_resp_bits[1:0];
            end else if (tmo) begin
                last_addr <= dtm_req_bits[RW-1:34];
                last_op   <= 2'd2;
            end

            // capture sees the status as it stood at the start of the cycle
            if (dmi_capture)
                dmi_rd_bits <= {last_addr, last_data,
                                (state != IDLE)     ? 2'd3 :
                                (dmistat != 2'd0)   ? dmistat : last_op};

            // first error wins; failure outranks busy raised in the same cycle
            if (dmireset)
                dmistat <= 2'd0;
            else if (dmistat == 2'd0) begin
                if (set_fail)      dmistat <= 2'd2;
                else if (set_busy) dmistat <= 2'd3;
            end
        end
    end

endmodule
